taus_range_sampler: RTL and testbench
=====================================

Name: taus_range_sampler

Overview:
- Consumes the 32-bit word stream from the combined Tausworthe generator.
- Turns that stream into uniformly distributed integers in [0, limit) by mask-and-reject sampling.
- Buffers accepted samples in a small FIFO behind a valid/ready output handshake.
- Sits directly downstream of the generator; feeds consumers that need bounded random indices.

Parameters:
- WIDTH, 16, sample and limit width in bits; legal range 1..32.
- DEPTH, 4, output FIFO depth; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rnd_in  in  32  random word from the generator.
- rnd_valid  in  1  rnd_in is valid this cycle; tie high for a free-running generator.
- rnd_ready  out  1  word is consumed on any cycle where rnd_valid && rnd_ready.
- limit  in  WIDTH  exclusive upper bound N.
- limit_load  in  1  one-cycle pulse that latches limit.
- sample  out  WIDTH  accepted sample from the FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer pops on sample_valid && sample_ready.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: sample=0, sample_valid=0, rnd_ready=0, busy=0, FIFO empty, limit_q=0, mask_q=0, state=IDLE.
- States:
  - IDLE: no usable limit. rnd_ready=0. limit_load → CALC.
  - CALC: one cycle. Computes mask_q = 2^k−1, the smallest such value ≥ limit_q−1, by leading-one detect of (limit_q−1). Exception: limit_q==1 gives mask_q=0. Next state: RUN if limit_q≠0, else IDLE.
  - RUN: rnd_ready = !fifo_full.
    - On a handshake: cand = rnd_in[WIDTH−1:0] & mask_q.
    - cand < limit_q: push cand into the FIFO.
    - Otherwise: drop the word (reject).
    - limit_load → CALC.
- limit_load in any state:
  - Latches limit into limit_q.
  - Flushes the FIFO on the same edge; sample_valid=0 the next cycle.
  - Any word handshaked in that same cycle is discarded.
- Latency: word handshaked at edge t appears at sample/sample_valid after edge t+1 (registered FIFO head). No combinational path from rnd_in to sample.
- Acceptance probability ≥ 1/2 for every limit ≥ 1.
- limit==1: every word is accepted and sample=0.
- FIFO:
  - Full: rnd_ready=0; words are neither consumed nor counted.
  - Push and pop in the same cycle when not full: both take effect; occupancy is unchanged.
  - No bypass when empty; the latency rule above always holds.
  - Pointers wrap modulo DEPTH; a count register of width log2(DEPTH)+1 distinguishes full from empty.
- sample_valid && !sample_ready: sample holds stable.
- rst mid-operation: returns to the reset values above. The limit must be reloaded afterwards.

Optional Feature:
- Macro: TAUS_RANGE_SAMPLER_STATS_EN.
- Defined:
  - Adds output ports accept_cnt[31:0] and reject_cnt[31:0].
  - Each counter increments on a RUN handshake with the matching outcome.
  - Counters wrap at 2^32, clear on rst and on limit_load, and are unaffected by stalls.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package taus_pkg holds:
  - TAUS_WORD_W=32.
  - The state enum typedef for IDLE/CALC/RUN.
  - A function computing the mask from limit−1.
- One sub-module, taus_sample_fifo (parameters WIDTH, DEPTH; push/pop/flush; registered head output).
- The sampler holds the FSM, the mask logic and the optional counters.

Test Plan:
- Basic accept: WIDTH=16, limit=10 loaded → mask 0xF. rnd_in=0x0000_0007 → sample=7 one cycle after the handshake. rnd_in=0xFFFF_FFF9 → sample=9.
- Reject: limit=10, rnd_in=0x0000_000C then 0x0000_000F → no sample_valid. If TAUS_RANGE_SAMPLER_STATS_EN is defined, reject_cnt=2.
- Backpressure: limit=16, sample_ready=0, 6 valid words → exactly 4 accepted and rnd_ready=0 from the cycle after the 4th push. Then sample_ready=1 → samples pop in push order.
- Reload mid-stream: FIFO holding 3 samples, limit_load with limit=5 → sample_valid=0 next cycle, CALC lasts 1 cycle, mask=0x7, and only new-limit samples (< 5) appear.
- Corner limits:
  - limit=1 → every word yields sample=0.
  - limit=0 → state returns to IDLE, rnd_ready=0, busy=0.
  - WIDTH=16, limit=0xFFFF → mask 0xFFFF; rnd_in=0x1234_FFFF is rejected.
- Reset: rst asserted with a non-empty FIFO in RUN → all outputs return to their reset values. After rst is released, no samples appear until the next limit_load.

Source files
------------

// File: rtl/taus_pkg.sv
// Shared definitions for the Tausworthe range sampler: word width, FSM states,
// and the mask helper used to bound candidate samples.
package taus_pkg;

  localparam int TAUS_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Smears the leading one of (limit - 1) downward, giving the smallest 2^k-1 >= limit-1.
  function automatic logic [TAUS_WORD_W-1:0] calc_mask(input logic [TAUS_WORD_W-1:0] lim_m1);
    logic [TAUS_WORD_W-1:0] m;
    m = lim_m1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/taus_sample_fifo.sv
// Small sample FIFO with a registered head: a pushed entry becomes visible one
// cycle after it is written, and the head holds stable until popped.
module taus_sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic [WIDTH-1:0] head,
  output logic             head_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW:0]      held;
  logic [WIDTH-1:0] head_q, head_d;
  logic             head_valid_q, head_valid_d;
  logic             push_en, pop_en;

  assign full       = (count_q == (AW+1)'(DEPTH));
  assign head       = head_q;
  assign head_valid = head_valid_q;

  always_comb begin
    push_en  = push && !full;
    pop_en   = pop && head_valid_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    if (push_en) mem_d[wr_ptr_q] = push_data;
    // Only entries stored before this edge may reach the head register.
    held         = count_q - (AW+1)'(pop_en);
    head_valid_d = (held != '0);
    head_d       = head_valid_d ? mem_q[rd_ptr_d] : '0;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      head_valid_d = 1'b0;
      head_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      head_valid_q <= head_valid_d;
    end
  end

endmodule

// File: rtl/taus_range_sampler.sv
// Mask-and-reject sampler turning generator words into uniform integers in [0, limit).
// Optional accept/reject counters are enabled with TAUS_RANGE_SAMPLER_STATS_EN.
//
//   state | meaning
//   IDLE  | no usable limit, words not consumed
//   CALC  | one cycle, derive mask_q from limit_q
//   RUN   | consume words, push in-range candidates
module taus_range_sampler
  import taus_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [TAUS_WORD_W-1:0] rnd_in,
  input  logic                   rnd_valid,
  output logic                   rnd_ready,
  input  logic [WIDTH-1:0]       limit,
  input  logic                   limit_load,
  output logic [WIDTH-1:0]       sample,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   busy
`ifdef TAUS_RANGE_SAMPLER_STATS_EN
  ,
  output logic [31:0]            accept_cnt,
  output logic [31:0]            reject_cnt
`endif
);

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       limit_q, limit_d;
  logic [WIDTH-1:0]       mask_q, mask_d;
  logic [TAUS_WORD_W-1:0] mask_full;
  logic [WIDTH-1:0]       cand;
  logic                   in_range;
  logic                   take;
  logic                   push;
  logic                   fifo_full;
  logic                   unused_bits;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (limit_load) state_d = CALC;
      CALC: begin
        if (limit_load)          state_d = CALC;
        else if (limit_q != '0)  state_d = RUN;
        else                     state_d = IDLE;
      end
      RUN:  if (limit_load) state_d = CALC;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rnd_ready = (state_q == RUN) && !fifo_full;
    busy      = (state_q != IDLE);
  end

  always_comb begin
    mask_full = calc_mask(TAUS_WORD_W'(limit_q) - TAUS_WORD_W'(1));
    limit_d   = limit_load ? limit : limit_q;
    mask_d    = (state_q == CALC) ? mask_full[WIDTH-1:0] : mask_q;
    cand      = rnd_in[WIDTH-1:0] & mask_q;
    in_range  = (cand < limit_q);
    // A word consumed in the same cycle as a reload belongs to the old limit.
    take      = rnd_valid && rnd_ready && (state_q == RUN) && !limit_load;
    push      = take && in_range;
  end

  assign unused_bits = ^{rnd_in, mask_full};

  always_ff @(posedge clk) begin
    if (rst) begin
      limit_q <= '0;
      mask_q  <= '0;
    end else begin
      limit_q <= limit_d;
      mask_q  <= mask_d;
    end
  end

  taus_sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (cand),
    .pop        (sample_ready),
    .flush      (limit_load),
    .full       (fifo_full),
    .head       (sample),
    .head_valid (sample_valid)
  );

`ifdef TAUS_RANGE_SAMPLER_STATS_EN
  logic [31:0] accept_cnt_q, accept_cnt_d;
  logic [31:0] reject_cnt_q, reject_cnt_d;

  always_comb begin
    accept_cnt_d = accept_cnt_q;
    reject_cnt_d = reject_cnt_q;
    if (limit_load) begin
      accept_cnt_d = '0;
      reject_cnt_d = '0;
    end else if (take) begin
      if (in_range) accept_cnt_d = accept_cnt_q + 32'd1;
      else          reject_cnt_d = reject_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accept_cnt_q <= '0;
      reject_cnt_q <= '0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign accept_cnt = accept_cnt_q;
  assign reject_cnt = reject_cnt_q;
`endif

endmodule

// File: tb/tb_taus_range_sampler.sv
// Bench for taus_range_sampler: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_taus_range_sampler;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   rnd_in = '0;
  logic          rnd_valid = 1'b0;
  logic          rnd_ready;
  logic [W-1:0]  limit = '0;
  logic          limit_load = 1'b0;
  logic [W-1:0]  sample;
  logic          sample_valid;
  logic          sample_ready = 1'b1;
  logic          busy;
`ifdef TAUS_RANGE_SAMPLER_STATS_EN
  logic [31:0]   accept_cnt;
  logic [31:0]   reject_cnt;
`endif

  taus_range_sampler #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .rnd_in       (rnd_in),
    .rnd_valid    (rnd_valid),
    .rnd_ready    (rnd_ready),
    .limit        (limit),
    .limit_load   (limit_load),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy)
`ifdef TAUS_RANGE_SAMPLER_STATS_EN
    ,
    .accept_cnt   (accept_cnt),
    .reject_cnt   (reject_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Smallest all-ones value not below lim-1, found by growing it one bit at a time.
  function automatic logic [W-1:0] ref_mask(input logic [W-1:0] lim);
    longint m;
    if (lim <= 1) return '0;
    m = 1;
    while (m < longint'(lim) - 1) m = m * 2 + 1;
    return W'(m);
  endfunction

  typedef struct packed {
    logic [W-1:0] v;
    int           c;
  } ent_t;

  ent_t         q[$];
  int           cyc = 0;
  int           mode = 0;   // 0: no limit, 1: deriving mask, 2: sampling
  logic [W-1:0] m_lim = '0;
  logic [W-1:0] m_mask = '0;
  int unsigned  m_acc = 0;
  int unsigned  m_rej = 0;

  always @(posedge clk) begin
    bit           vpre, rdy, hs, pp;
    logic [W-1:0] cand;
    vpre = (q.size() > 0) && (cyc > q[0].c);
    rdy  = (mode == 2) && (q.size() < D);
    hs   = rnd_valid && rdy;
    pp   = vpre && sample_ready;
    cyc++;
    if (rst) begin
      q.delete();
      mode = 0; m_lim = '0; m_mask = '0; m_acc = 0; m_rej = 0;
    end else if (limit_load) begin
      m_lim = limit;
      q.delete();
      mode = 1; m_acc = 0; m_rej = 0;
    end else begin
      if (pp) void'(q.pop_front());
      if (hs) begin
        cand = rnd_in[W-1:0] & m_mask;
        if (cand < m_lim) begin
          q.push_back('{v: cand, c: cyc});
          m_acc++;
        end else begin
          m_rej++;
        end
      end
      if (mode == 1) begin
        m_mask = ref_mask(m_lim);
        mode   = (m_lim != 0) ? 2 : 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = (q.size() > 0) && (cyc > q[0].c);
    chk("m_sample_valid", sample_valid, ev);
    if (ev) chk("m_sample", sample, q[0].v);
    chk("m_rnd_ready", rnd_ready, (mode == 2) && (q.size() < D));
    chk("m_busy", busy, mode != 0);
`ifdef TAUS_RANGE_SAMPLER_STATS_EN
    chk("m_accept_cnt", accept_cnt, m_acc);
    chk("m_reject_cnt", reject_cnt, m_rej);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] lim);
    limit      = lim;
    limit_load = 1'b1;
    step();
    limit_load = 1'b0;
    step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_valid"}, sample_valid, 0);
    chk({tag, "_rnd_ready"}, rnd_ready, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef TAUS_RANGE_SAMPLER_STATS_EN
    chk({tag, "_accept"}, accept_cnt, 0);
    chk({tag, "_reject"}, reject_cnt, 0);
`endif
  endtask

  initial begin
    repeat (3) step();
    chk_reset_values("reset");
    rst = 1'b0;
    step();

    // Basic accept, one-cycle head latency.
    load(16'd10);
    chk("mask_10", dut.mask_q, 16'hF);
    rnd_in = 32'h0000_0007; rnd_valid = 1'b1;
    step();
    rnd_valid = 1'b0;
    chk("latency_not_early", sample_valid, 0);
    step();
    chk("acc7_valid", sample_valid, 1);
    chk("acc7_value", sample, 7);
    rnd_in = 32'hFFFF_FFF9; rnd_valid = 1'b1;
    step();
    rnd_valid = 1'b0;
    step();
    chk("acc9_valid", sample_valid, 1);
    chk("acc9_value", sample, 9);
    step();

    // Reject.
    rnd_in = 32'h0000_000C; rnd_valid = 1'b1;
    step();
    rnd_in = 32'h0000_000F;
    step();
    rnd_valid = 1'b0;
    step();
    chk("reject_none", sample_valid, 0);
    step();
    chk("reject_none2", sample_valid, 0);
`ifdef TAUS_RANGE_SAMPLER_STATS_EN
    chk("reject_cnt_2", reject_cnt, 2);
`endif

    // Backpressure.
    load(16'd16);
    sample_ready = 1'b0;
    rnd_valid    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rnd_in = 32'(3 + 2 * i);
      step();
      if (i == 3) chk("bp_ready_after_4th", rnd_ready, 0);
    end
    chk("bp_ready_still_low", rnd_ready, 0);
    rnd_valid = 1'b0;
    step();
    chk("bp_hold", sample, 3);
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_order_valid", sample_valid, 1);
      chk("bp_order_value", sample, 3 + 2 * i);
      step();
    end
    chk("bp_drained", sample_valid, 0);

    // Reload mid-stream.
    sample_ready = 1'b0;
    rnd_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_in = 32'(i + 1);
      step();
    end
    rnd_valid = 1'b0;
    step();
    chk("reload_pre_full", sample_valid, 1);
    limit = 16'd5; limit_load = 1'b1;
    step();
    limit_load = 1'b0;
    chk("reload_flush", sample_valid, 0);
    chk("reload_calc_busy", busy, 1);
    chk("reload_calc_ready", rnd_ready, 0);
    step();
    chk("reload_mask_7", dut.mask_q, 16'h7);
    chk("reload_calc_one_cycle", rnd_ready, 1);
    for (int i = 0; i < 40; i++) begin
      rnd_valid    = 1'($urandom_range(0, 1));
      rnd_in       = $urandom;
      sample_ready = 1'($urandom_range(0, 1));
      step();
      if (sample_valid) chk("reload_range", sample < 5, 1);
    end
    rnd_valid = 1'b0;

    // limit = 1.
    sample_ready = 1'b1;
    load(16'd1);
    chk("mask_1", dut.mask_q, 0);
    for (int i = 0; i < 20; i++) begin
      rnd_valid = 1'b1;
      rnd_in    = $urandom;
      step();
      if (i > 0) chk("lim1_valid", sample_valid, 1);
      if (sample_valid) chk("lim1_zero", sample, 0);
    end
    rnd_valid = 1'b0;

    // limit = 0.
    load(16'd0);
    chk("lim0_busy", busy, 0);
    chk("lim0_ready", rnd_ready, 0);

    // limit = 0xFFFF.
    load(16'hFFFF);
    chk("mask_ffff", dut.mask_q, 16'hFFFF);
    rnd_in = 32'h1234_FFFF; rnd_valid = 1'b1;
    step();
    rnd_valid = 1'b0;
    step();
    chk("ffff_reject", sample_valid, 0);
    rnd_in = 32'h0000_FFFE; rnd_valid = 1'b1;
    step();
    rnd_valid = 1'b0;
    step();
    chk("fffe_valid", sample_valid, 1);
    chk("fffe_value", sample, 16'hFFFE);
    step();

    // Randomized traffic with occasional reloads.
    for (int i = 0; i < 500; i++) begin
      if (i == 0 || $urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 3))
          0: limit = W'($urandom_range(0, 3));
          1: limit = W'($urandom_range(1, 40));
          2: limit = W'($urandom);
          default: limit = W'(1 << $urandom_range(0, 15));
        endcase
        limit_load = 1'b1;
      end else begin
        limit_load = 1'b0;
      end
      rnd_valid    = ($urandom_range(0, 3) != 0);
      rnd_in       = $urandom;
      sample_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    limit_load = 1'b0;

    // Reset mid-operation.
    load(16'd16);
    sample_ready = 1'b0;
    rnd_valid    = 1'b1;
    rnd_in       = 32'h2;
    step();
    step();
    rnd_valid = 1'b0;
    step();
    chk("rst_pre_valid", sample_valid, 1);
    rst = 1'b1;
    step();
    chk_reset_values("rst_mid");
    rst          = 1'b0;
    rnd_valid    = 1'b1;
    sample_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rnd_in = $urandom;
      step();
      chk("rst_after_valid", sample_valid, 0);
      chk("rst_after_busy", busy, 0);
    end
    rnd_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
